// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared pipeline constants for the MEM stage: datapath widths
//                and the store-data select codes driven by the memory
//                forwarding unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_WORD_W = 32;
    localparam int c_REG_W  = 5;

    // Store-data select codes; 2'b11 is reserved and behaves like MEMSRC_RT.
    localparam logic [1:0] MEMSRC_RT      = 2'b00;
    localparam logic [1:0] MEMSRC_MEMDATA = 2'b01;
    localparam logic [1:0] MEMSRC_ALU     = 2'b10;

    // Picks the value a store writes: the un-forwarded rt value, or one of
    // the two results held in MEM/WB by the instruction one cycle ahead.
    function automatic logic [c_WORD_W-1:0] store_data_sel(
        input logic [1:0]          memsrc,
        input logic [c_WORD_W-1:0] rt_data,
        input logic [c_WORD_W-1:0] mem_data,
        input logic [c_WORD_W-1:0] alu_data
    );
        logic [c_WORD_W-1:0] result;
        case (memsrc)
            MEMSRC_MEMDATA: result = mem_data;
            MEMSRC_ALU:     result = alu_data;
            default:        result = rt_data;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Word-addressed data memory. Combinational read, write at the
//                rising edge, whole array cleared in a single reset cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import mem_stage_pkg::*;
#(
    parameter int MEM_WORDS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [c_WORD_W-1:0]          wdata,
    output logic [c_WORD_W-1:0]          rdata
);

    logic [c_WORD_W-1:0] r_mem [MEM_WORDS];

    // Clear every word on reset (a concurrent write is discarded), else store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Asynchronous read of the current contents; a same-edge write is not
    // visible until after the edge.
    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of the 5-stage MIPS pipeline. Store-data forwarding
//                mux, data memory, MEM/WB pipeline register and the
//                write-back data select.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_LSB  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_mem_memread,
    input  logic                ex_mem_memwrite,
    input  logic                ex_mem_regwrite,
    input  logic                ex_mem_memtoreg,
    input  logic [c_WORD_W-1:0] ex_mem_aluresult,
    input  logic [c_WORD_W-1:0] ex_mem_writedata,
    input  logic [c_REG_W-1:0]  ex_mem_dst,
    input  logic [1:0]          memsrc,
    output logic                mem_wb_memread,
    output logic                mem_wb_regwrite,
    output logic                mem_wb_memtoreg,
    output logic [c_WORD_W-1:0] mem_wb_readdata,
    output logic [c_WORD_W-1:0] mem_wb_aluresult,
    output logic [c_REG_W-1:0]  mem_wb_dst,
    output logic [c_WORD_W-1:0] wb_data
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_WORD_W-1:0] w_store_data;
    logic [c_WORD_W-1:0] w_rdata;

    logic                r_memread;
    logic                r_regwrite;
    logic                r_memtoreg;
    logic [c_WORD_W-1:0] r_readdata;
    logic [c_WORD_W-1:0] r_aluresult;
    logic [c_REG_W-1:0]  r_dst;

    // Upper address bits and the byte offset are dropped: addresses wrap and
    // misaligned accesses silently hit the containing word.
    assign w_idx = ex_mem_aluresult[ADDR_LSB +: c_IDX_W];

    // Store-data mux; the forwarded values come from registered MEM/WB state,
    // so there is no combinational path back through this stage.
    always_comb begin
        w_store_data = store_data_sel(memsrc, ex_mem_writedata,
                                      r_readdata, r_aluresult);
    end

    data_memory #(
        .MEM_WORDS (MEM_WORDS)
    ) u_data_memory (
        .clk   (clk),
        .reset (reset),
        .we    (ex_mem_memwrite),
        .addr  (w_idx),
        .wdata (w_store_data),
        .rdata (w_rdata)
    );

    // MEM/WB pipeline register: loads every cycle, read data zeroed for
    // non-load instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_memread   <= 1'b0;
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_readdata  <= '0;
            r_aluresult <= '0;
            r_dst       <= '0;
        end else begin
            r_memread   <= ex_mem_memread;
            r_regwrite  <= ex_mem_regwrite;
            r_memtoreg  <= ex_mem_memtoreg;
            r_readdata  <= ex_mem_memread ? w_rdata : '0;
            r_aluresult <= ex_mem_aluresult;
            r_dst       <= ex_mem_dst;
        end
    end

    assign mem_wb_memread   = r_memread;
    assign mem_wb_regwrite  = r_regwrite;
    assign mem_wb_memtoreg  = r_memtoreg;
    assign mem_wb_readdata  = r_readdata;
    assign mem_wb_aluresult = r_aluresult;
    assign mem_wb_dst       = r_dst;

    assign wb_data = r_memtoreg ? r_readdata : r_aluresult;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage: directed scenarios with
//                literal expectations, then randomized traffic checked every
//                cycle against a word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int MEM_WORDS = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        memread, memwrite, regwrite, memtoreg;
    logic [31:0] aluresult, writedata;
    logic [4:0]  dst;
    logic [1:0]  memsrc;

    logic        o_memread, o_regwrite, o_memtoreg;
    logic [31:0] o_readdata, o_aluresult, o_wb_data;
    logic [4:0]  o_dst;

    // Reference model state: memory contents and the MEM/WB fields.
    logic [31:0] m_mem [MEM_WORDS];
    logic        m_memread, m_regwrite, m_memtoreg;
    logic [31:0] m_readdata, m_aluresult;
    logic [4:0]  m_dst;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_LSB  (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_mem_memread   (memread),
        .ex_mem_memwrite  (memwrite),
        .ex_mem_regwrite  (regwrite),
        .ex_mem_memtoreg  (memtoreg),
        .ex_mem_aluresult (aluresult),
        .ex_mem_writedata (writedata),
        .ex_mem_dst       (dst),
        .memsrc           (memsrc),
        .mem_wb_memread   (o_memread),
        .mem_wb_regwrite  (o_regwrite),
        .mem_wb_memtoreg  (o_memtoreg),
        .mem_wb_readdata  (o_readdata),
        .mem_wb_aluresult (o_aluresult),
        .mem_wb_dst       (o_dst),
        .wb_data          (o_wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic mr, input logic mw, input logic rw,
                          input logic mt, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] d, input logic [1:0] src);
        reset = r; memread = mr; memwrite = mw; regwrite = rw; memtoreg = mt;
        aluresult = alu; writedata = wd; dst = d; memsrc = src;
    endtask

    // Advance one clock: evaluate the model on the presented inputs, let the
    // DUT take the edge, then compare every MEM/WB output and wb_data.
    task automatic do_cycle();
        int          idx;
        logic [31:0] store_val;
        logic [31:0] old_word;
        idx = int'((aluresult / 4) % MEM_WORDS);
        if (memsrc == 2'd1)      store_val = m_readdata;
        else if (memsrc == 2'd2) store_val = m_aluresult;
        else                     store_val = writedata;
        old_word = m_mem[idx];
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
            m_memread = 0; m_regwrite = 0; m_memtoreg = 0;
            m_readdata = 0; m_aluresult = 0; m_dst = 0;
        end else begin
            if (memwrite) m_mem[idx] = store_val;
            m_memread   = memread;
            m_regwrite  = regwrite;
            m_memtoreg  = memtoreg;
            m_readdata  = memread ? old_word : 32'h0;
            m_aluresult = aluresult;
            m_dst       = dst;
        end
        @(posedge clk);
        #1;
        chk("mem_wb_memread",   {31'h0, o_memread},  {31'h0, m_memread});
        chk("mem_wb_regwrite",  {31'h0, o_regwrite}, {31'h0, m_regwrite});
        chk("mem_wb_memtoreg",  {31'h0, o_memtoreg}, {31'h0, m_memtoreg});
        chk("mem_wb_readdata",  o_readdata,  m_readdata);
        chk("mem_wb_aluresult", o_aluresult, m_aluresult);
        chk("mem_wb_dst",       {27'h0, o_dst}, {27'h0, m_dst});
        chk("wb_data",          o_wb_data, m_memtoreg ? m_readdata : m_aluresult);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle();

        // Reset with a store pending: store dropped, MEM/WB cleared.
        set_in(1, 0, 1, 1, 1, 32'h10, 32'hDEAD_BEEF, 5'd3, 2'b00);
        do_cycle();
        chk("reset_readdata_lit", o_readdata, 32'h0);
        chk("reset_wb_data_lit",  o_wb_data,  32'h0);
        set_in(0, 1, 0, 1, 1, 32'h10, 0, 5'd4, 2'b00);
        do_cycle();
        chk("reset_lw_0x10_lit", o_readdata, 32'h0);

        // Plain store then load of the same word.
        set_in(0, 0, 1, 0, 0, 32'h20, 32'h1234_5678, 5'd0, 2'b00);
        do_cycle();
        set_in(0, 1, 0, 1, 1, 32'h20, 0, 5'd5, 2'b00);
        do_cycle();
        chk("plain_lw_readdata_lit", o_readdata, 32'h1234_5678);
        chk("plain_lw_wb_data_lit",  o_wb_data,  32'h1234_5678);

        // lw -> sw forwarding from MEM/WB read data.
        set_in(0, 0, 1, 0, 0, 32'h04, 32'hCAFE_F00D, 5'd0, 2'b00);
        do_cycle();
        set_in(0, 1, 0, 1, 1, 32'h04, 0, 5'd8, 2'b00);
        do_cycle();
        set_in(0, 0, 1, 0, 0, 32'h08, 32'h0, 5'd8, 2'b01);
        do_cycle();
        set_in(0, 1, 0, 1, 1, 32'h08, 0, 5'd10, 2'b00);
        do_cycle();
        chk("lw_sw_fwd_lit", o_readdata, 32'hCAFE_F00D);

        // ALU -> sw forwarding from MEM/WB ALU result.
        set_in(0, 0, 0, 1, 0, 32'h77, 0, 5'd9, 2'b00);
        do_cycle();
        set_in(0, 0, 1, 0, 0, 32'h0C, 32'h0, 5'd9, 2'b10);
        do_cycle();
        set_in(0, 1, 0, 1, 1, 32'h0C, 0, 5'd11, 2'b00);
        do_cycle();
        chk("alu_sw_fwd_lit", o_readdata, 32'h0000_0077);

        // Address wrap with reserved select 11 (MEM/WB holds 0x77 / 0x0C).
        set_in(0, 0, 1, 0, 0, 32'h104, 32'hA5A5_A5A5, 5'd0, 2'b11);
        do_cycle();
        set_in(0, 1, 0, 1, 1, 32'h004, 0, 5'd12, 2'b00);
        do_cycle();
        chk("wrap_sel11_lit", o_readdata, 32'hA5A5_A5A5);

        // Non-load instruction: read data forced to zero.
        set_in(0, 0, 0, 1, 0, 32'h55, 32'hFFFF_FFFF, 5'd13, 2'b00);
        do_cycle();
        chk("nonload_readdata_lit", o_readdata,  32'h0);
        chk("nonload_alu_lit",      o_aluresult, 32'h55);
        chk("nonload_wb_data_lit",  o_wb_data,   32'h55);

        // Simultaneous read and write: write lands, read returns the old word.
        set_in(0, 1, 1, 1, 1, 32'h20, 32'h0BAD_0BAD, 5'd1, 2'b00);
        do_cycle();
        chk("rw_same_cycle_lit", o_readdata, 32'h1234_5678);

        // Randomized traffic, including occasional mid-program resets.
        for (int n = 0; n < 2000; n++) begin
            logic [31:0] alu;
            logic        mr, mw;
            int          kind;
            kind = $urandom_range(0, 15);
            mr = (kind < 6);
            mw = (kind >= 6 && kind < 12) || (kind == 15);
            if ($urandom_range(0, 3) == 0) alu = $urandom;
            else                           alu = $urandom & 32'h0000_003F;
            set_in(($urandom_range(0, 63) == 0), mr, mw, 1'($urandom), 1'($urandom),
                   alu, $urandom, 5'($urandom), 2'($urandom));
            do_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
